// File: rtl/bpsk_modulator_nco_if.sv
// Bit-in / sample-out bundle of the BPSK modulator: the master offers symbol bits
// and consumes modulated samples, the slave is the modulator.
interface bpsk_modulator_nco_if #(
  parameter int SAMPLE_W = 16
);
  logic                       bit_in;
  logic                       bit_valid;
  logic                       bit_ready;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid;
  logic                       symbol_start;
  logic                       underrun;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, sample_out, sample_valid, symbol_start, underrun
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, sample_out, sample_valid, symbol_start, underrun
  );
endinterface

// File: rtl/bpsk_modulator_nco.sv
// BPSK transmit source: free-running phase accumulator into a cosine ROM, one bit held per
// SPS samples, sign inverted for 1. Define BPSK_DIFF_ENCODE_EN for differential (DBPSK) coding.
module bpsk_modulator_nco #(
  parameter int PHASE_W    = 12,
  parameter int PHASE_STEP = 256,
  parameter int SPS        = 8,
  parameter int SAMPLE_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_init,
  input  logic               phase_load,
  bpsk_modulator_nco_if.slave bus,
  output logic               state_dbg_o,
  output logic [PHASE_W-1:0] phase_dbg_o
);
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int N     = 1 << PHASE_W;
  localparam logic signed [SAMPLE_W-1:0] POS_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] NEG_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Integer Bhaskara sine of the quarter-shifted phase; exact at 0, +/-90 and 180 degrees.
  function automatic logic signed [SAMPLE_W-1:0] cos_entry(input int idx);
    longint half, q, p, num, den, amp, mag;
    half = longint'(N / 2);
    q    = longint'((idx + N / 4) % N);
    p    = (q < half) ? q : q - half;
    num  = 16 * p * (half - p);
    den  = 5 * half * half - 4 * p * (half - p);
    amp  = (longint'(1) << (SAMPLE_W - 1)) - 1;
    mag  = (amp * num) / den;
    return (q < half) ? SAMPLE_W'(mag) : SAMPLE_W'(-mag);
  endfunction

  logic signed [SAMPLE_W-1:0] lut [N];
  for (genvar g = 0; g < N; g++) begin : g_cosine_lut
    assign lut[g] = cos_entry(g);
  end

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           sym_cnt_q, sym_cnt_d;
  logic                       sym_q, sym_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       symbol_start_q, symbol_start_d;
  logic                       underrun_q, underrun_d;
  logic                       ready, accept, last_sample, sym_new;
  logic signed [SAMPLE_W-1:0] cos_val, neg_val;

`ifdef BPSK_DIFF_ENCODE_EN
  logic prev_sym_q;
  assign sym_new = bus.bit_in ^ prev_sym_q;
  always_ff @(posedge clk) begin
    if (rst)         prev_sym_q <= 1'b0;
    else if (accept) prev_sym_q <= sym_new;
  end
`else
  assign sym_new = bus.bit_in;
`endif

  // Handshake: a bit transfers in any cycle where bit_valid and bit_ready are both high.
  // bit_ready depends only on en, state and sym_cnt, never on bit_valid.
  assign last_sample = (sym_cnt_q == CNT_W'(SPS - 1));
  assign accept      = bus.bit_valid & ready;
  assign phase_d     = phase_load ? phase_init : phase_q + PHASE_W'(PHASE_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sym_cnt_q      <= '0;
      sym_q          <= 1'b0;
      phase_q        <= phase_init;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      symbol_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sym_cnt_q      <= sym_cnt_d;
      sym_q          <= sym_d;
      phase_q        <= phase_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      symbol_start_q <= symbol_start_d;
      underrun_q     <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    sym_d      = sym_q;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          sym_cnt_d = '0;
          sym_d     = sym_new;
        end
      end
      RUN: begin
        if (!last_sample) begin
          sym_cnt_d = sym_cnt_q + CNT_W'(1);
        end else if (accept) begin
          sym_cnt_d = '0;
          sym_d     = sym_new;
        end else begin
          // en low here means a deliberate stop, so only a missing bit counts as underrun.
          state_d    = IDLE;
          sym_cnt_d  = '0;
          underrun_d = en;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    ready = en;
        RUN:     ready = en & last_sample;
        default: ready = 1'b0;
      endcase
    end
    cos_val        = lut[phase_q];
    neg_val        = (cos_val == NEG_MIN) ? POS_MAX : -cos_val;
    sample_valid_d = (state_d == RUN);
    symbol_start_d = accept;
    sample_d       = '0;
    if (state_d == RUN) sample_d = sym_d ? neg_val : cos_val;
  end

  assign bus.bit_ready    = ready;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.symbol_start = symbol_start_q;
  assign bus.underrun     = underrun_q;
  assign state_dbg_o      = (state_q == RUN);
  assign phase_dbg_o      = phase_q;
endmodule
